cla_seq_add: RTL and testbench

CLA_SEQ_ADD -- requirements
Module: cla_seq_add

---
 rtl/cla_seq_add_pkg.sv | 18 +
 rtl/cla_12bits.sv | 76 +++++++
 rtl/cla_seq_add.sv | 99 +++++++++
 tb/tb_cla_seq_add.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_add_pkg.sv
// Shared constants, FSM states and helpers for the chunk-serial CLA adder.
package cla_seq_add_pkg;

    localparam int CHUNK_W = 12;
    localparam int GRP_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    function automatic logic ovf_bit(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_12bits.sv
// 12-bit two-level carry-lookahead adder: 4-bit groups with group generate/propagate.
// Exposes block pm/gm instead of a carry-out so the caller forms the carry itself.
module cla_12bits
    import cla_seq_add_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               pm,
    output logic               gm
);

    localparam int NGRP = CHUNK_W / GRP_W;

    logic [CHUNK_W-1:0] p, g, c;
    logic [NGRP-1:0]    gp, gg, gc;
    logic               term;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        gp   = '0;
        gg   = '0;
        gc   = '0;
        c    = '0;
        gm   = 1'b0;
        term = 1'b0;

        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[j*GRP_W +: GRP_W];
            for (int m = 0; m < GRP_W; m++) begin
                term = g[j*GRP_W+m];
                for (int n = m + 1; n < GRP_W; n++) term = term & p[j*GRP_W+n];
                gg[j] = gg[j] | term;
            end
        end

        // Group carry-ins as flat sums of products over cin and lower groups
        gc[0] = cin;
        for (int j = 0; j < NGRP - 1; j++) begin
            term = cin;
            for (int n = 0; n <= j; n++) term = term & gp[n];
            gc[j+1] = term;
            for (int m = 0; m <= j; m++) begin
                term = gg[m];
                for (int n = m + 1; n <= j; n++) term = term & gp[n];
                gc[j+1] = gc[j+1] | term;
            end
        end

        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < GRP_W; i++) begin
                term = gc[j];
                for (int n = 0; n < i; n++) term = term & p[j*GRP_W+n];
                c[j*GRP_W+i] = term;
                for (int m = 0; m < i; m++) begin
                    term = g[j*GRP_W+m];
                    for (int n = m + 1; n < i; n++) term = term & p[j*GRP_W+n];
                    c[j*GRP_W+i] = c[j*GRP_W+i] | term;
                end
            end
        end

        for (int m = 0; m < NGRP; m++) begin
            term = gg[m];
            for (int n = m + 1; n < NGRP; n++) term = term & gp[n];
            gm = gm | term;
        end
    end

    assign pm  = &gp;
    assign sum = p ^ c;

endmodule

// File: rtl/cla_seq_add.sv
// Chunk-serial W-bit adder: one 12-bit CLA reused LSB chunk first, valid/ready on both sides.
// Throughput is one operation per WORDS+2 cycles (accept, WORDS chunks, DONE).
module cla_seq_add
    import cla_seq_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK_W*WORDS-1:0] in_a,
    input  logic [CHUNK_W*WORDS-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK_W*WORDS-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf
);

    localparam int W  = CHUNK_W * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t             state;
    logic [W-1:0]       a_q, b_q;
    logic               carry_q;
    logic [IW-1:0]      idx_q;
    logic [CHUNK_W-1:0] a_chunk, b_chunk, sum_chunk;
    logic               pm, gm, carry_nxt;

    assign a_chunk   = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
    assign b_chunk   = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
    assign carry_nxt = gm | (pm & carry_q);

    cla_12bits u_cla (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .sum (sum_chunk),
        .pm  (pm),
        .gm  (gm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        carry_q  <= in_cin;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out_sum[int'(idx_q)*CHUNK_W +: CHUNK_W] <= sum_chunk;
                    carry_q <= carry_nxt;
                    if (idx_q == LAST_IDX) begin
                        // Top chunk's sum MSB is the result sign bit
                        out_cout  <= carry_nxt;
                        out_ovf   <= ovf_bit(a_q[W-1], b_q[W-1], sum_chunk[CHUNK_W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_add.sv
// Randomized self-checking bench for cla_seq_add against an arithmetic reference model.
module tb_cla_seq_add;

    localparam int WORDS = 4;
    localparam int W     = 12 * WORDS;
    localparam int TMO   = 100;
    localparam int NRAND = 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, out_cout, out_ovf;
    logic [W-1:0] out_sum;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    cla_seq_add #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        for (int i = 0; i < WORDS; i++) r[i*12 +: 12] = 12'($urandom);
        return r;
    endfunction

    // Reference: {ovf, cout, sum} from plain wide addition
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    // Present one operand set, scramble inputs after accept, return cycles until out_valid
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output int lat);
        int guard;
        guard = 0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        while (!in_ready && guard < TMO) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < TMO) begin
            in_a = rnd_w(); in_b = rnd_w(); in_cin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: sum=%h cout=%b ovf=%b expected zeros", out_sum, out_cout, out_ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[3], vb[3], vs[3];
        logic         vc[3], vco[3], vov[3];
        int           lat;
        va[0] = 48'h000000000FFF; vb[0] = 48'h000000000001; vc[0] = 1'b0;
        vs[0] = 48'h000000001000; vco[0] = 1'b0; vov[0] = 1'b0;
        va[1] = 48'hFFFFFFFFFFFF; vb[1] = 48'h000000000000; vc[1] = 1'b1;
        vs[1] = 48'h000000000000; vco[1] = 1'b1; vov[1] = 1'b0;
        va[2] = 48'h7FFFFFFFFFFF; vb[2] = 48'h000000000001; vc[2] = 1'b0;
        vs[2] = 48'h800000000000; vco[2] = 1'b0; vov[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], vc[i], lat);
            checks++;
            if (lat !== WORDS + 1) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, WORDS + 1);
            end
            checks++;
            if (out_sum !== vs[i] || out_cout !== vco[i] || out_ovf !== vov[i]) begin
                errors++;
                $display("FAIL dir%0d_result: sum=%h cout=%b ovf=%b expected %h %b %b",
                         i, out_sum, out_cout, out_ovf, vs[i], vco[i], vov[i]);
            end
            consume();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_return: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] a, b;
        logic         cin;
        logic [W+1:0] exp;
        int           lat;
        a = rnd_w(); b = rnd_w(); cin = 1'($urandom);
        exp = model(a, b, cin);
        issue(a, b, cin, lat);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = rnd_w(); in_b = rnd_w(); in_cin = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({out_ovf, out_cout, out_sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: ovf,cout,sum=%h valid=%b ready=%b expected %h 1 0",
                         k, {out_ovf, out_cout, out_sum}, out_valid, in_ready, exp);
            end
        end
        // in_valid stays high through the release cycle: must not be accepted there
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || {out_ovf, out_cout, out_sum} !== exp) begin
            errors++;
            $display("FAIL idle_hold: in_ready=%b out=%h expected 1 %h", in_ready, {out_ovf, out_cout, out_sum}, exp);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: in_ready=%b expected 1", in_ready);
        end
        in_a = 48'hABCABCABCABC; in_b = 48'h111111111111; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: valid=%b ready=%b sum=%h cout=%b ovf=%b expected 0 1 0 0 0",
                     out_valid, in_ready, out_sum, out_cout, out_ovf);
        end
        issue(48'd3, 48'd4, 1'b0, lat);
        checks++;
        if (lat !== WORDS + 1 || out_sum !== 48'd7 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: lat=%0d sum=%h cout=%b ovf=%b expected %0d 7 0 0",
                     lat, out_sum, out_cout, out_ovf, WORDS + 1);
        end
        consume();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         cin;
        logic [W+1:0] exp;
        int           lat, hs0, stall;
        hs0 = hs_cnt;
        for (int n = 0; n < NRAND; n++) begin
            repeat ($urandom_range(0, 2)) begin
                in_a = rnd_w(); in_b = rnd_w();
                @(posedge clk); #1;
            end
            a = rnd_w(); b = rnd_w(); cin = 1'($urandom);
            case ($urandom_range(0, 3))
                1:       b = ~a;
                2:       b = -a;
                3:       begin a = a >> 1; b = b >> 1; end
                default: ;
            endcase
            exp = model(a, b, cin);
            issue(a, b, cin, lat);
            checks++;
            if (lat !== WORDS + 1) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, WORDS + 1);
            end
            stall = $urandom_range(0, 3);
            for (int k = 0; k <= stall; k++) begin
                checks++;
                if ({out_ovf, out_cout, out_sum} !== exp || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd%0d_result: a=%h b=%h cin=%b got ovf,cout,sum=%h valid=%b expected %h",
                             n, a, b, cin, {out_ovf, out_cout, out_sum}, out_valid, exp);
                end
                if (k < stall) begin
                    in_a = rnd_w(); in_b = rnd_w();
                    @(posedge clk); #1;
                end
            end
            consume();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_dup: out_valid=%b expected 0 after handshake", n, out_valid);
            end
        end
        checks++;
        if (hs_cnt - hs0 !== NRAND) begin
            errors++;
            $display("FAIL rnd_count: handshakes=%0d expected %0d", hs_cnt - hs0, NRAND);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
